// File: rtl/hazard_controller_if.sv
// Pipeline-side view of the hazard controller: IF/ID and ID/EX operand fields,
// branch/jump/memory status in, stall/flush controls and statistics out.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IF_ID_Rs;
  logic [4:0]       IF_ID_Rt;
  logic             IF_ID_UsesRt;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_RegDst;
  logic             JumpIn;
  logic             BranchTaken;
  logic             MemBusy;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             EX_MEM_Flush;
  logic             DangerSel;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, ID_EX_MemRead, ID_EX_RegDst,
           JumpIn, BranchTaken, MemBusy,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
           DangerSel, StallCount, FlushCount
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, ID_EX_MemRead, ID_EX_RegDst,
           JumpIn, BranchTaken, MemBusy,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
           DangerSel, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_controller.sv
// Load-use / branch / jump hazard sequencer for the five-stage MIPS pipeline.
// Stretches load-use stalls to LOAD_USE_STALL bubbles and keeps saturating stall/flush statistics.
module hazard_controller #(
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 16
) (
  input  logic                Clk,
  input  logic                Rst,
  hazard_controller_if.slave  hz
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [2:0] STALL_INIT = 3'(LOAD_USE_STALL - 1);

  state_t           state_r;
  state_t           nextState_s;
  logic [2:0]       rem_r;
  logic [2:0]       nextRem_s;
  logic [CNT_W-1:0] stallCnt_r;
  logic [CNT_W-1:0] flushCnt_r;
  logic             hazard_s;
  logic             stallInc_s;
  logic             flushInc_s;
  logic             pcWrite_s;
  logic             ifIdWrite_s;
  logic             ifIdFlush_s;
  logic             idExFlush_s;
  logic             exMemFlush_s;
  logic             dangerSel_s;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    if (value == {CNT_W{1'b1}}) begin
      satInc = value;
    end else begin
      satInc = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Load-use detection; $0 is never a real dependency
  always_comb begin
    hazard_s = hz.ID_EX_MemRead && (hz.ID_EX_RegDst != 5'd0) &&
               ((hz.ID_EX_RegDst == hz.IF_ID_Rs) ||
                (hz.IF_ID_UsesRt && (hz.ID_EX_RegDst == hz.IF_ID_Rt)));
  end

  // Priority decode of control outputs and FSM next state
  always_comb begin
    pcWrite_s    = 1'b1;
    ifIdWrite_s  = 1'b1;
    ifIdFlush_s  = 1'b0;
    idExFlush_s  = 1'b0;
    exMemFlush_s = 1'b0;
    dangerSel_s  = 1'b0;
    stallInc_s   = 1'b0;
    flushInc_s   = 1'b0;
    nextState_s  = state_r;
    nextRem_s    = rem_r;
    if (Rst) begin
      pcWrite_s    = 1'b0;
      ifIdWrite_s  = 1'b0;
      ifIdFlush_s  = 1'b1;
      idExFlush_s  = 1'b1;
      exMemFlush_s = 1'b1;
      dangerSel_s  = 1'b1;
      nextState_s  = RUN;
      nextRem_s    = 3'd0;
    end else if (hz.MemBusy) begin
      pcWrite_s   = 1'b0;
      ifIdWrite_s = 1'b0;
    end else if (hz.BranchTaken) begin
      ifIdFlush_s  = 1'b1;
      idExFlush_s  = 1'b1;
      exMemFlush_s = 1'b1;
      flushInc_s   = 1'b1;
      nextState_s  = RUN;
      nextRem_s    = 3'd0;
    end else if ((state_r == STALL) || hazard_s) begin
      pcWrite_s   = 1'b0;
      ifIdWrite_s = 1'b0;
      dangerSel_s = 1'b1;
      stallInc_s  = 1'b1;
      // The hazard input is not re-examined once the stall is running
      if (state_r == STALL) begin
        if (rem_r <= 3'd1) begin
          nextState_s = RUN;
          nextRem_s   = 3'd0;
        end else begin
          nextRem_s = rem_r - 3'd1;
        end
      end else if (LOAD_USE_STALL > 1) begin
        nextState_s = STALL;
        nextRem_s   = STALL_INIT;
      end else begin
        nextState_s = RUN;
        nextRem_s   = 3'd0;
      end
    end else if (hz.JumpIn) begin
      ifIdFlush_s = 1'b1;
      flushInc_s  = 1'b1;
    end else begin
      pcWrite_s   = 1'b1;
      ifIdWrite_s = 1'b1;
    end
  end

  // FSM state and remaining-bubble register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= RUN;
      rem_r   <= 3'd0;
    end else begin
      state_r <= nextState_s;
      rem_r   <= nextRem_s;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stallCnt_r <= {CNT_W{1'b0}};
      flushCnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stallInc_s) begin
        stallCnt_r <= satInc(stallCnt_r);
      end else begin
        stallCnt_r <= stallCnt_r;
      end
      if (flushInc_s) begin
        flushCnt_r <= satInc(flushCnt_r);
      end else begin
        flushCnt_r <= flushCnt_r;
      end
    end
  end

  assign hz.PCWrite      = pcWrite_s;
  assign hz.IF_ID_Write  = ifIdWrite_s;
  assign hz.IF_ID_Flush  = ifIdFlush_s;
  assign hz.ID_EX_Flush  = idExFlush_s;
  assign hz.EX_MEM_Flush = exMemFlush_s;
  assign hz.DangerSel    = dangerSel_s;
  assign hz.StallCount   = stallCnt_r;
  assign hz.FlushCount   = flushCnt_r;

endmodule

// File: tb/tb_hazard_controller.sv
// Table-driven bench for hazard_controller: instance A stretches stalls to 2 bubbles, B to 3.
// Expected outputs are queued as each vector is driven and checked on the falling edge.
module tb_hazard_controller;

  logic       clk;
  logic       rst;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       usesRt;
  logic       memRead;
  logic [4:0] regDst;
  logic       jump;
  logic       branch;
  logic       busy;

  hazard_controller_if #(.CNT_W(16)) ifA ();
  hazard_controller_if #(.CNT_W(16)) ifB ();

  assign ifA.IF_ID_Rs = rs;       assign ifB.IF_ID_Rs = rs;
  assign ifA.IF_ID_Rt = rt;       assign ifB.IF_ID_Rt = rt;
  assign ifA.IF_ID_UsesRt = usesRt;   assign ifB.IF_ID_UsesRt = usesRt;
  assign ifA.ID_EX_MemRead = memRead; assign ifB.ID_EX_MemRead = memRead;
  assign ifA.ID_EX_RegDst = regDst;   assign ifB.ID_EX_RegDst = regDst;
  assign ifA.JumpIn = jump;       assign ifB.JumpIn = jump;
  assign ifA.BranchTaken = branch;    assign ifB.BranchTaken = branch;
  assign ifA.MemBusy = busy;      assign ifB.MemBusy = busy;

  hazard_controller #(.LOAD_USE_STALL(2), .CNT_W(16)) dutA (.Clk(clk), .Rst(rst), .hz(ifA));
  hazard_controller #(.LOAD_USE_STALL(3), .CNT_W(16)) dutB (.Clk(clk), .Rst(rst), .hz(ifB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, DangerSel}
  localparam logic [5:0] O_NRM = 6'b11_000_0;
  localparam logic [5:0] O_STL = 6'b00_000_1;
  localparam logic [5:0] O_RST = 6'b00_111_1;
  localparam logic [5:0] O_BSY = 6'b00_000_0;
  localparam logic [5:0] O_BR  = 6'b11_111_0;
  localparam logic [5:0] O_JMP = 6'b11_100_0;

  typedef struct {
    int         id;
    bit         sel;
    bit         chk;
    bit         rst, busy, br, jmp, mr, ur;
    logic [4:0] rd, rs, rt;
    logic [5:0] out;
    logic [15:0] sc, fc;
  } vec_t;

  vec_t tbl[$];
  vec_t expQ[$];
  int   nCmp = 0;
  int   nBad = 0;

  task automatic add(input bit sel, input bit chk, input bit r, input bit bz, input bit br,
                     input bit jp, input bit mr, input logic [4:0] rd, input logic [4:0] s,
                     input logic [4:0] t, input bit ur, input logic [5:0] o,
                     input logic [15:0] sc, input logic [15:0] fc);
    vec_t v;
    v.id = tbl.size(); v.sel = sel; v.chk = chk;
    v.rst = r; v.busy = bz; v.br = br; v.jmp = jp; v.mr = mr; v.ur = ur;
    v.rd = rd; v.rs = s; v.rt = t; v.out = o; v.sc = sc; v.fc = fc;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; busy = v.busy; branch = v.br; jump = v.jmp;
    memRead = v.mr; regDst = v.rd; rs = v.rs; rt = v.rt; usesRt = v.ur;
    if (v.chk) expQ.push_back(v);
  endtask

  // Pop one expectation per checked cycle and compare the selected instance
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      vec_t e;
      logic [5:0]  gotO;
      logic [15:0] gotS, gotF;
      e = expQ.pop_front();
      if (e.sel) begin
        gotO = {ifB.PCWrite, ifB.IF_ID_Write, ifB.IF_ID_Flush, ifB.ID_EX_Flush,
                ifB.EX_MEM_Flush, ifB.DangerSel};
        gotS = ifB.StallCount; gotF = ifB.FlushCount;
      end else begin
        gotO = {ifA.PCWrite, ifA.IF_ID_Write, ifA.IF_ID_Flush, ifA.ID_EX_Flush,
                ifA.EX_MEM_Flush, ifA.DangerSel};
        gotS = ifA.StallCount; gotF = ifA.FlushCount;
      end
      nCmp++;
      if (gotO !== e.out) begin
        nBad++;
        $display("FAIL vec%0d ctrl: got %b want %b", e.id, gotO, e.out);
      end
      nCmp++;
      if ((gotS !== e.sc) || (gotF !== e.fc)) begin
        nBad++;
        $display("FAIL vec%0d counts: got stall=%0h flush=%0h want stall=%0h flush=%0h",
                 e.id, gotS, gotF, e.sc, e.fc);
      end
    end
  end

  initial begin
    vec_t v;
    rst = 1'b1; busy = 1'b0; branch = 1'b0; jump = 1'b0; memRead = 1'b0;
    regDst = 5'd0; rs = 5'd0; rt = 5'd0; usesRt = 1'b0;

    //  sel chk rst bsy br jp mr  rd     rs     rt    ur  out    sc      fc     (instance A, 2 bubbles)
    add(0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_RST, 16'd0, 16'd0);
    add(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_RST, 16'd0, 16'd0);
    add(0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 1, O_NRM, 16'd0, 16'd0);
    add(0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 1, O_NRM, 16'd0, 16'd0);
    add(0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 1, O_NRM, 16'd0, 16'd0);
    add(0, 1, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd2, 0, O_STL, 16'd0, 16'd0);
    add(0, 1, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd2, 0, O_STL, 16'd1, 16'd0);
    add(0, 1, 0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd2, 0, O_NRM, 16'd2, 16'd0);
    add(0, 1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, O_NRM, 16'd2, 16'd0);
    add(0, 1, 0, 0, 0, 0, 1, 5'd9, 5'd3, 5'd9, 0, O_NRM, 16'd2, 16'd0);
    add(0, 1, 0, 0, 0, 0, 1, 5'd9, 5'd3, 5'd9, 1, O_STL, 16'd2, 16'd0);
    add(0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd3, 5'd9, 1, O_STL, 16'd3, 16'd0);
    add(0, 1, 0, 0, 0, 1, 0, 5'd0, 5'd3, 5'd9, 1, O_JMP, 16'd4, 16'd0);
    add(0, 1, 0, 0, 1, 0, 0, 5'd0, 5'd3, 5'd9, 1, O_BR,  16'd4, 16'd1);
    add(0, 1, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd9, 0, O_STL, 16'd4, 16'd2);
    add(0, 1, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd9, 0, O_STL, 16'd5, 16'd2);
    add(0, 1, 0, 0, 0, 1, 0, 5'd5, 5'd5, 5'd9, 0, O_JMP, 16'd6, 16'd2);
    add(0, 1, 0, 1, 1, 0, 1, 5'd5, 5'd5, 5'd9, 0, O_BSY, 16'd6, 16'd3);
    add(0, 1, 0, 0, 1, 0, 1, 5'd5, 5'd5, 5'd9, 0, O_BR,  16'd6, 16'd3);
    add(0, 1, 0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd9, 0, O_NRM, 16'd6, 16'd4);
    // MemBusy in the middle of a 2-bubble stall
    add(0, 1, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0, 0, O_STL, 16'd6, 16'd4);
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 1, 0, 0, 1, 5'd7, 5'd7, 5'd0, 0, O_BSY, 16'd7, 16'd4);
    add(0, 1, 0, 0, 0, 0, 0, 5'd7, 5'd7, 5'd0, 0, O_STL, 16'd7, 16'd4);
    add(0, 1, 0, 0, 0, 0, 0, 5'd7, 5'd7, 5'd0, 0, O_NRM, 16'd8, 16'd4);
    // Reset in the middle of a stall
    add(0, 1, 0, 0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0, O_STL, 16'd8, 16'd4);
    add(0, 1, 1, 0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0, O_RST, 16'd9, 16'd4);
    add(0, 1, 0, 0, 0, 0, 0, 5'd4, 5'd4, 5'd0, 0, O_NRM, 16'd0, 16'd0);
    add(0, 1, 0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd8, 1, O_NRM, 16'd0, 16'd0);
    // Instance B, 3 bubbles: branch with the hazard, branch aborting a stall, full stall
    add(1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_RST, 16'd0, 16'd0);
    add(1, 1, 0, 0, 1, 0, 1, 5'd6, 5'd6, 5'd0, 0, O_BR,  16'd0, 16'd0);
    add(1, 1, 0, 0, 0, 0, 0, 5'd6, 5'd6, 5'd0, 0, O_NRM, 16'd0, 16'd1);
    add(1, 1, 0, 0, 0, 0, 1, 5'd6, 5'd6, 5'd0, 0, O_STL, 16'd0, 16'd1);
    add(1, 1, 0, 0, 0, 0, 0, 5'd6, 5'd6, 5'd0, 0, O_STL, 16'd1, 16'd1);
    add(1, 1, 0, 0, 1, 0, 0, 5'd6, 5'd6, 5'd0, 0, O_BR,  16'd2, 16'd1);
    add(1, 1, 0, 0, 0, 0, 0, 5'd6, 5'd6, 5'd0, 0, O_NRM, 16'd2, 16'd2);
    add(1, 1, 0, 0, 0, 0, 1, 5'd6, 5'd6, 5'd0, 0, O_STL, 16'd2, 16'd2);
    add(1, 1, 0, 0, 0, 0, 0, 5'd6, 5'd6, 5'd0, 0, O_STL, 16'd3, 16'd2);
    add(1, 1, 0, 0, 0, 0, 0, 5'd6, 5'd6, 5'd0, 0, O_STL, 16'd4, 16'd2);
    add(1, 1, 0, 0, 0, 0, 0, 5'd6, 5'd6, 5'd0, 0, O_NRM, 16'd5, 16'd2);
    add(0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_RST, 16'd0, 16'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(tbl[i]);
    end

    // Saturation: continuous hazard on A gives one bubble per cycle
    v = tbl[0];
    v.rst = 1'b0; v.mr = 1'b1; v.rd = 5'd12; v.rs = 5'd12; v.chk = 1'b0;
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk); #1;
      drive(v);
    end
    v.chk = 1'b1; v.id = 1000; v.out = O_NRM; v.sc = 16'hFFFE; v.fc = 16'd0; v.mr = 1'b0;
    @(posedge clk); #1; drive(v);
    v.mr = 1'b1; v.out = O_STL;
    for (int i = 0; i < 6; i++) begin
      v.id = 1001 + i;
      v.sc = (i == 0) ? 16'hFFFE : 16'hFFFF;
      @(posedge clk); #1; drive(v);
    end
    v.id = 1007; v.mr = 1'b0; v.out = O_NRM; v.sc = 16'hFFFF;
    @(posedge clk); #1; drive(v);

    repeat (2) @(posedge clk);
    if (expQ.size() != 0) begin
      nCmp++;
      nBad++;
      $display("FAIL drain: got %0d pending want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
